// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: valid/ready handshake with a two-entry skid buffer and flush-to-bubble.
// Optional stall counter is enabled by defining PIPE_STAGE_STALL_CNT_EN.
module pipe_stage_reg #(
  parameter int                PC_W     = 12,
  parameter int                INST_W   = 16,
  parameter logic [INST_W-1:0] NOP_INST = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   pc_in,
  input  logic [INST_W-1:0] inst_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   pc_out,
  output logic [INST_W-1:0] inst_out
`ifdef PIPE_STAGE_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t state, state_nxt;
  entry_t main_q, skid_q, in_e;
  logic   acc, pop;
  logic   main_ld_in, main_ld_skid, skid_ld;
  logic   clr;

  assign in_e = '{pc: pc_in, inst: inst_in};
  assign clr  = reset || flush;
  assign acc  = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // State register
  always_ff @(posedge clk) begin
    if (clr) state <= EMPTY;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (acc) state_nxt = ONE;
      ONE: begin
        if (acc && !pop)      state_nxt = TWO;
        else if (!acc && pop) state_nxt = EMPTY;
      end
      TWO:     if (pop) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  // Output / load-enable decode
  always_comb begin
    out_valid    = (state != EMPTY);
    main_ld_in   = 1'b0;
    main_ld_skid = 1'b0;
    skid_ld      = 1'b0;
    case (state)
      EMPTY: main_ld_in = acc;
      ONE: begin
        main_ld_in = acc && pop;
        skid_ld    = acc && !pop;
      end
      TWO:     main_ld_skid = pop;
      default: ;
    endcase
  end

  // in_ready is its own flop so out_ready never reaches it combinationally
  always_ff @(posedge clk) begin
    if (clr) in_ready <= 1'b1;
    else     in_ready <= (state_nxt != TWO);
  end

  always_ff @(posedge clk) begin
    if (clr)               main_q <= '{pc: '0, inst: NOP_INST};
    else if (main_ld_in)   main_q <= in_e;
    else if (main_ld_skid) main_q <= skid_q;
  end

  always_ff @(posedge clk) begin
    if (reset)        skid_q <= '0;
    else if (skid_ld) skid_q <= in_e;
  end

  assign pc_out   = main_q.pc;
  assign inst_out = main_q.inst;

`ifdef PIPE_STAGE_STALL_CNT_EN
  // Saturating; flush deliberately leaves it alone
  always_ff @(posedge clk) begin
    if (reset)
      stall_cnt <= '0;
    else if (out_valid && !out_ready && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomized + directed bench for pipe_stage_reg against a queue-based FIFO model.
module tb_pipe_stage_reg;
  localparam int          PC_W   = 12;
  localparam int          INST_W = 16;
  localparam logic [15:0] NOP    = 16'h0013;

  logic              clk = 1'b0;
  logic              reset, flush, in_valid, out_ready;
  logic              in_ready, out_valid;
  logic [PC_W-1:0]   pc_in, pc_out;
  logic [INST_W-1:0] inst_in, inst_out;
`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [15:0]       stall_cnt;
`endif

  pipe_stage_reg #(.PC_W(PC_W), .INST_W(INST_W), .NOP_INST(NOP)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .pc_in(pc_in), .inst_in(inst_in),
    .out_valid(out_valid), .out_ready(out_ready), .pc_out(pc_out), .inst_out(inst_out)
`ifdef PIPE_STAGE_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;

  // Model: a 2-deep FIFO plus the value shown when empty
  logic [27:0] mq[$];
  logic [27:0] mlast;
  int          mcnt;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_all();
    logic [27:0] e;
    e = (mq.size() > 0) ? mq[0] : mlast;
    chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
    chk("in_ready",  32'(in_ready),  32'(mq.size() < 2));
    chk("pc_out",    32'(pc_out),    32'(e[27:16]));
    chk("inst_out",  32'(inst_out),  32'(e[15:0]));
`ifdef PIPE_STAGE_STALL_CNT_EN
    chk("stall_cnt", 32'(stall_cnt), 32'(mcnt));
`endif
  endtask

  task automatic step(input logic rst, input logic fl, input logic iv, input logic ordy,
                      input logic [11:0] pc, input logic [15:0] inst);
    int sz;
    reset = rst; flush = fl; in_valid = iv; out_ready = ordy; pc_in = pc; inst_in = inst;
    @(posedge clk);
    sz = mq.size();
    if (rst) begin
      mq.delete(); mlast = {12'h000, NOP}; mcnt = 0;
    end else begin
      if (sz > 0 && !ordy && mcnt < 65535) mcnt++;
      if (fl) begin
        mq.delete(); mlast = {12'h000, NOP};
      end else begin
        if (sz > 0 && ordy) mlast = mq.pop_front();
        if (iv && sz < 2) mq.push_back({pc, inst});
      end
    end
    @(negedge clk);
    check_all();
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; pc_in = '0; inst_in = '0;
    mlast = '0; mcnt = 0;
    @(negedge clk);
    step(1, 0, 0, 0, 0, 0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_inst",  32'(inst_out), 32'(NOP));

    // Full-rate stream
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 1, 1, 12'(i), 16'($urandom));
      chk("stream_pc", 32'(pc_out), 32'(i));
    end
    step(0, 0, 0, 1, 0, 0);

    // Backpressure: 0x012 is refused until re-presented
    step(0, 0, 1, 0, 12'h010, 16'h1010);
    step(0, 0, 1, 0, 12'h011, 16'h1011);
    step(0, 0, 1, 0, 12'h012, 16'h1012);
    chk("bp_ready", 32'(in_ready), 32'd0);
    chk("bp_hold",  32'(pc_out), 32'h010);
    step(0, 0, 1, 1, 12'h012, 16'h1012);
    chk("bp_pop1", 32'(pc_out), 32'h011);
    step(0, 0, 1, 1, 12'h012, 16'h1012);
    chk("bp_pop2", 32'(pc_out), 32'h012);
    step(0, 0, 0, 1, 0, 0);

    // Flush while full, with a same-cycle input that must vanish
    step(0, 0, 1, 0, 12'h01A, 16'h101A);
    step(0, 0, 1, 0, 12'h01B, 16'h101B);
    step(0, 1, 1, 0, 12'h020, 16'h1020);
    chk("fl_valid", 32'(out_valid), 32'd0);
    chk("fl_pc",    32'(pc_out), 32'd0);
    chk("fl_inst",  32'(inst_out), 32'(NOP));
    chk("fl_ready", 32'(in_ready), 32'd1);
    repeat (3) step(0, 0, 0, 1, 0, 0);

    // Reset while full and stalled
    step(0, 0, 1, 0, 12'h02A, 16'h102A);
    step(0, 0, 1, 0, 12'h02B, 16'h102B);
    repeat (3) step(0, 0, 0, 0, 0, 0);
    step(1, 0, 1, 1, 12'h02C, 16'h102C);
    chk("rm_valid", 32'(out_valid), 32'd0);
    chk("rm_ready", 32'(in_ready), 32'd1);
    chk("rm_pc",    32'(pc_out), 32'd0);
    step(0, 0, 1, 0, 12'h030, 16'h1030);
    chk("rm_next", 32'(pc_out), 32'h030);
    step(0, 0, 0, 1, 0, 0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 5),
           ($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 60),
           12'($urandom), 16'($urandom));
    end

`ifdef PIPE_STAGE_STALL_CNT_EN
    // Saturation: one held entry, downstream stalled for 70000 cycles
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 12'h040, 16'h1040);
    in_valid = 1'b0;
    repeat (70000) @(posedge clk);
    @(negedge clk);
    chk("sat_cnt", 32'(stall_cnt), 32'h0000FFFF);
    chk("sat_pc",  32'(pc_out), 32'h040);
`endif

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register carrying a PC/instruction pair between two CPU pipeline stages, for example fetch to decode. It replaces the plain enable-gated stage register with a valid/ready handshake, a two-entry skid buffer (registered `in_ready`, full throughput), and a synchronous flush that injects a bubble. Generic widths and NOP encoding let the same block serve IF/ID, ID/EX and later stages.

## Interface
Parameters:
- `PC_W`, default 12, PC field width
- `INST_W`, default 16, instruction field width
- `NOP_INST`, default 0 (`INST_W` bits), instruction value presented after reset or flush

Ports:
- `clk`  in  1  rising-edge clock; single clock domain
- `reset`  in  1  synchronous, active-high reset
- `flush`  in  1  synchronous bubble insert; drops all held entries
- `in_valid`  in  1  upstream holds a valid entry
- `in_ready`  out  1  stage can accept; driven directly from a flop
- `pc_in`  in  `PC_W`  upstream PC
- `inst_in`  in  `INST_W`  upstream instruction
- `out_valid`  out  1  `pc_out`/`inst_out` hold a valid entry
- `out_ready`  in  1  downstream consumes the entry this cycle
- `pc_out`  out  `PC_W`  PC to next stage
- `inst_out`  out  `INST_W`  instruction to next stage
- `stall_cnt`  out  16  stall counter; present only with `PIPE_STAGE_STALL_CNT_EN`

## Operation
- Storage: main register (`main_v`, pc, inst) drives the outputs. Skid register (`skid_v`, pc, inst) absorbs one entry when downstream stalls.
- Accept: `acc = in_valid && in_ready`. Pop: `pop = out_valid && out_ready`.
- `in_ready = !skid_v`, registered. `out_valid = main_v`.
- States by occupancy:
  - EMPTY (`main_v=0`, `skid_v=0`): on `acc`, the main register loads the input and the block goes to ONE.
  - ONE (`main_v=1`, `skid_v=0`):
    - `acc && pop`: main loads the input; stay in ONE.
    - `acc && !pop`: skid loads the input; go to TWO.
    - `!acc && pop`: go to EMPTY.
    - Otherwise: hold.
  - TWO (`main_v=1`, `skid_v=1`): `in_ready=0`. On `pop`, main loads the skid contents, skid is cleared, and the block goes to ONE.
- Ordering is strictly FIFO. No entry is duplicated or lost except by flush.
- Priority: `reset` > `flush` > normal operation.
- Flush:
  - Next state is EMPTY.
  - Main data is set to pc=0 and inst=`NOP_INST`.
  - Any input accepted in the same cycle is discarded.
  - A pop in the same cycle still counts as consumed.
- While `out_valid=1 && out_ready=0`, `pc_out`/`inst_out` hold stable.
- When `out_valid=0`, outputs keep their last value: 0/`NOP_INST` after reset or flush, otherwise the last popped entry.

## Timing
- Reset values, in the cycle after `reset` is sampled high:
  - `out_valid=0`, `in_ready=1`, `pc_out=0`, `inst_out=NOP_INST`, skid empty, `stall_cnt=0`.
- Handshakes in a cycle where `reset=1` are ignored.
- Latency: an entry accepted at edge N in EMPTY appears with `out_valid=1` after edge N; it can pop at edge N+1.
- Throughput: 1 entry/cycle whenever `out_ready=1`.
- Backpressure: `in_ready` falls one cycle after the first stalled accept, and rises the cycle after the pop that drains the skid.
- No combinational path from `out_ready` to `in_ready`, or from `in_valid` to `out_valid`.
- Reset or flush mid-stall: both entries are dropped in one cycle; `in_ready=1` on the next cycle.

## Configuration
- `PIPE_STAGE_STALL_CNT_EN` defined:
  - `stall_cnt` port exists.
  - It increments once per cycle with `out_valid && !out_ready`, saturates at 16'hFFFF, and clears only on `reset`. Flush does not clear it.
- Not defined: the port and counter are absent. Datapath behaviour is identical.

## Test plan
- Stream with no stall: `in_valid=1` and `out_ready=1` every cycle, `pc_in` 0x000..0x007 -> `pc_out` 0x000..0x007 on consecutive cycles, 1 cycle after input, `in_ready` constantly 1.
- Backpressure: feed 0x010, 0x011, 0x012 with `out_ready=0` for 3 cycles -> 0x010 held on outputs, 0x011 in skid, `in_ready=0`, 0x012 not accepted until it is re-presented. After `out_ready=1`, outputs pop 0x010, 0x011, 0x012 in order.
- Flush when full: state TWO, assert `flush` for 1 cycle with `in_valid=1` and `pc_in=0x020` -> next cycle `out_valid=0`, `inst_out=NOP_INST`, `pc_out=0`, `in_ready=1`, and 0x020 never appears.
- Reset mid-operation: state TWO with `stall_cnt=5`, `reset` for 1 cycle -> all outputs at reset values and `stall_cnt=0`. A subsequent entry 0x030 emerges after 1 cycle.
- Counter saturation (macro defined): hold `out_valid=1`, `out_ready=0` for 70000 cycles -> `stall_cnt=16'hFFFF`, and it does not wrap.
